// File: rtl/alu_pkg.sv
// ALU shared definitions: operation encoding and default datapath width.
// Imported by the alu core; the led7seg decoder has no dependency on it.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

endpackage

// File: rtl/led7seg.sv
// Hex to seven-segment decoder, active-high, bit0=a ... bit6=g.
// Purely combinational; all segments dark when en is low.
module led7seg (
    input  logic [3:0] in,
    input  logic       en,
    output logic [6:0] out
);

    // Map the nibble to its glyph, blanked when disabled
    always_comb begin
        out = 7'h00;
        if (en) begin
            unique case (in)
                4'h0: out = 7'h3F;
                4'h1: out = 7'h06;
                4'h2: out = 7'h5B;
                4'h3: out = 7'h4F;
                4'h4: out = 7'h66;
                4'h5: out = 7'h6D;
                4'h6: out = 7'h7D;
                4'h7: out = 7'h07;
                4'h8: out = 7'h7F;
                4'h9: out = 7'h6F;
                4'hA: out = 7'h77;
                4'hB: out = 7'h7C;
                4'hC: out = 7'h39;
                4'hD: out = 7'h5E;
                4'hE: out = 7'h79;
                4'hF: out = 7'h71;
            endcase
        end
    end

endmodule

// File: rtl/alu.sv
// Single-stage registered ALU: ADD/SUB/AND/OR, one result per cycle.
// Define ALU_SEG_EN to add the seg port driven by a led7seg decoder.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
`ifdef ALU_SEG_EN
    ,
    output logic [6:0]       seg
`endif
);

    op_e              op;
    logic [WIDTH-1:0] res;

    assign op = op_e'(op_in);

    // Operation mux; carries and borrows wrap modulo 2^WIDTH
    always_comb begin
        res = '0;
        unique case (op)
            OP_ADD: res = a_in + b_in;
            OP_SUB: res = a_in - b_in;
            OP_AND: res = a_in & b_in;
            OP_OR:  res = a_in | b_in;
        endcase
    end

    // Result register; holds its value across idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= res;
            end
        end
    end

`ifdef ALU_SEG_EN
    logic [3:0] nib;

    assign nib = 4'(out);

    led7seg u_seg (
        .in  (nib),
        .en  (out_valid),
        .out (seg)
    );
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed cases, full op/operand sweep, random traffic.
// Stimulus pushes expected post-edge state; a negedge monitor pops and checks.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [1:0]   op_in = 2'b00;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] out;
    logic         out_valid;
`ifdef ALU_SEG_EN
    logic [6:0]   seg;
    logic [6:0]   segtab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
`endif

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_in     (op_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
`ifdef ALU_SEG_EN
        ,
        .seg       (seg)
`endif
    );

    typedef struct {
        bit    v;
        int    d;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   held  = 0;

    function automatic int ref_op(int op, int a, int b);
        case (op)
            0: return (a + b) % M;
            1: return (a - b + M) % M;
            2: return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic drive(bit r, bit v, int op, int a, int b, string tag);
        exp_t e;
        rst      = r;
        in_valid = v;
        op_in    = 2'(op);
        a_in     = W'(a);
        b_in     = W'(b);
        if (r) begin
            held = 0;
            e.v  = 1'b0;
        end else if (v) begin
            held = ref_op(op, a, b);
            e.v  = 1'b1;
        end else begin
            e.v  = 1'b0;
        end
        e.d   = held;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per clock edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t         e;
            logic [W-1:0] wd;
            e  = sb.pop_front();
            wd = e.d[W-1:0];
            total++;
            if (out_valid !== e.v || out !== wd) begin
                bad++;
                $display("FAIL %s t=%0t got v=%b out=%h want v=%b out=%h",
                         e.tag, $time, out_valid, out, e.v, wd);
            end
`ifdef ALU_SEG_EN
            begin
                logic [6:0] ws;
                ws = e.v ? segtab[wd] : 7'h00;
                total++;
                if (seg !== ws) begin
                    bad++;
                    $display("FAIL seg_%s t=%0t got %h want %h",
                             e.tag, $time, seg, ws);
                end
            end
`endif
        end
    end

    initial begin
        drive(1, 1, OP_ADD, 5, 3, "rst_drop");
        drive(1, 0, OP_ADD, 0, 0, "rst_hold");
        drive(0, 0, OP_ADD, 1, 1, "idle_after_rst");
        drive(0, 1, OP_ADD, 15, 1, "add_wrap");
        drive(0, 1, OP_ADD, 7, 8, "add_7_8");
        drive(0, 1, OP_SUB, 0, 1, "sub_wrap");
        drive(0, 1, OP_AND, 12, 10, "and_c_a");
        drive(0, 1, OP_OR, 12, 10, "or_c_a");
        drive(0, 1, OP_ADD, 2, 4, "add_6");
        drive(0, 0, OP_SUB, 9, 3, "hold_6_a");
        drive(0, 0, OP_OR, 1, 14, "hold_6_b");
        drive(0, 1, OP_ADD, 5, 5, "add_a");
        drive(0, 0, OP_ADD, 0, 0, "seg_blank");
        drive(1, 1, OP_OR, 15, 15, "rst_mid");
        drive(0, 0, OP_OR, 15, 15, "rst_mid_hold");

        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < M; a++) begin
                for (int b = 0; b < M; b++) begin
                    drive(0, 1, op, a, b, "sweep");
                    if ($urandom_range(0, 7) == 0) begin
                        drive(0, 0, $urandom_range(0, 3),
                              $urandom_range(0, M - 1),
                              $urandom_range(0, M - 1), "sweep_gap");
                    end
                end
            end
        end

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 24) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3),
                  $urandom_range(0, M - 1),
                  $urandom_range(0, M - 1), "random");
        end

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
